// File: rtl/restoring_divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional two's-complement mode via RESTORING_DIV_SIGNED_EN (adds the signed_op port).
module restoring_divider_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
`ifdef RESTORING_DIV_SIGNED_EN
    input  logic         signed_op,
`endif
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic          accept;
    logic          last;
    logic [N:0]    a;
    logic [N-1:0]  qr;
    logic [N-1:0]  m;
    logic [CW-1:0] cnt;
    logic          dz_q;
    logic [N-1:0]  dvd_q;
    logic          negq;
    logic          negr;

    logic          dvd_neg;
    logic          dsr_neg;
    logic [N-1:0]  dvd_mag;
    logic [N-1:0]  dsr_mag;

    logic [N:0]    sh;
    logic [N:0]    diff;
    logic [N:0]    a_n;
    logic [N-1:0]  qr_n;

    logic [N-1:0]  q_fix;
    logic [N-1:0]  r_fix;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (accept) begin
                    state_n = (divisor == '0) ? S_DONE : S_RUN;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // state decode
    always_comb begin
        busy   = 1'b0;
        accept = 1'b0;
        last   = 1'b0;
        unique case (state)
            S_IDLE: accept = start;
            S_RUN: begin
                busy = 1'b1;
                last = (cnt == CW'(1));
            end
            S_DONE: accept = start;
            default: ;
        endcase
    end

    // operand magnitudes; plain pass-through in the unsigned build
    always_comb begin
`ifdef RESTORING_DIV_SIGNED_EN
        dvd_neg = signed_op & dividend[N-1];
        dsr_neg = signed_op & divisor[N-1];
`else
        dvd_neg = 1'b0;
        dsr_neg = 1'b0;
`endif
        dvd_mag = dvd_neg ? -dividend : dividend;
        dsr_mag = dsr_neg ? -divisor : divisor;
    end

    // one restoring step on {A,Qr}
    always_comb begin
        sh   = {a[N-1:0], qr[N-1]};
        diff = sh - {1'b0, m};
        if (diff[N]) begin
            a_n  = sh;
            qr_n = {qr[N-2:0], 1'b0};
        end else begin
            a_n  = diff;
            qr_n = {qr[N-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a     <= '0;
            qr    <= '0;
            m     <= '0;
            cnt   <= '0;
            dz_q  <= 1'b0;
            dvd_q <= '0;
            negq  <= 1'b0;
            negr  <= 1'b0;
        end else if (accept) begin
            a     <= '0;
            qr    <= dvd_mag;
            m     <= dsr_mag;
            cnt   <= CW'(N);
            dz_q  <= (divisor == '0);
            dvd_q <= dividend;
            negq  <= dvd_neg ^ dsr_neg;
            negr  <= dvd_neg;
        end else if (state == S_RUN) begin
            a   <= a_n;
            qr  <= qr_n;
            cnt <= cnt - CW'(1);
        end
    end

    // sign fix-up; most-negative / -1 wraps back to most-negative
    always_comb begin
        if (dz_q) begin
            q_fix = '1;
            r_fix = dvd_q;
        end else begin
            q_fix = negq ? -qr : qr;
            r_fix = negr ? -a[N-1:0] : a[N-1:0];
        end
    end

    // result registers are loaded as DONE is left, so they hold until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_DONE) begin
                quotient    <= q_fix;
                remainder   <= r_fix;
                div_by_zero <= dz_q;
            end else if (accept) begin
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Self-checking bench for restoring_divider_seq: vector table, corner
// sequences and random operands against an arithmetic reference.
module tb_restoring_divider_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         sop;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    restoring_divider_seq #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
`ifdef RESTORING_DIV_SIGNED_EN
        .signed_op  (sop),
`endif
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void ref_div(
        input  logic [N-1:0] a,
        input  logic [N-1:0] b,
        input  logic         s,
        output logic [N-1:0] q,
        output logic [N-1:0] r
    );
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            q = N'(sa / sb);
            r = N'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // issue one op from idle; lat = edges after the accepting edge until done
    task automatic do_op(
        input  logic [N-1:0] a,
        input  logic [N-1:0] b,
        input  logic         s,
        output int           lat
    );
        @(negedge clk);
        dividend = a;
        divisor  = b;
        sop      = s;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, (b != '0));
        chk("dz_clear_on_start", div_by_zero, 0);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                lat = i;
                break;
            end
            if (i == 1) begin
                @(posedge clk);
                #1;
                if (done) begin
                    lat = 1;
                    break;
                end
            end
        end
    endtask

    logic [N-1:0] eq;
    logic [N-1:0] er;
    int           lat;
    int           first;
    int           second;
    int           ndone;
    logic [N-1:0] sq;
    logic [N-1:0] sr;

    initial begin
        vt[0] = '{8'd11,  8'd3,   8'd3,   8'd2,  1'b0, 9};
        vt[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9};
        vt[2] = '{8'd5,   8'd0,   8'hFF,  8'd5,  1'b1, 1};
        vt[3] = '{8'd200, 8'd13,  8'd15,  8'd5,  1'b0, 9};
        vt[4] = '{8'd0,   8'd7,   8'd0,   8'd0,  1'b0, 9};
        vt[5] = '{8'd7,   8'd200, 8'd0,   8'd7,  1'b0, 9};
        vt[6] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9};
        vt[7] = '{8'd0,   8'd0,   8'hFF,  8'd0,  1'b1, 1};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        sop      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        // vector table
        for (int k = 0; k < 8; k++) begin
            do_op(vt[k].a, vt[k].b, 1'b0, lat);
            chk($sformatf("vec%0d_lat", k), lat, vt[k].lat);
            chk($sformatf("vec%0d_q", k), quotient, vt[k].q);
            chk($sformatf("vec%0d_r", k), remainder, vt[k].r);
            chk($sformatf("vec%0d_dz", k), div_by_zero, vt[k].dz);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_pulse", k), done, 0);
            chk($sformatf("vec%0d_q_hold", k), quotient, vt[k].q);
        end

        // back-to-back with start held through DONE; operands change mid-run
        @(negedge clk);
        dividend = 8'd20;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dividend = 8'd255;
        divisor  = 8'd1;
        first    = -1;
        second   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (first < 0) begin
                    first = i;
                    start = 1'b0;
                    chk("b2b_q1", quotient, 2);
                    chk("b2b_r1", remainder, 6);
                end else begin
                    second = i;
                    chk("b2b_q2", quotient, 255);
                    chk("b2b_r2", remainder, 0);
                    break;
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_edge", first, 9);
        chk("b2b_gap", second - first, 9);

        // start while busy is ignored
        @(negedge clk);
        dividend = 8'd17;
        divisor  = 8'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        first = -1;
        sq    = '0;
        sr    = '0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 4) begin
                dividend = 8'd3;
                divisor  = 8'd1;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            if (i == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = i;
                    sq    = quotient;
                    sr    = remainder;
                end
            end
        end
        chk("busy_start_ndone", ndone, 1);
        chk("busy_start_lat", first, 9);
        chk("busy_start_q", sq, 1);
        chk("busy_start_r", sr, 8);

        // reset mid-operation
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd13;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_dz", div_by_zero, 0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        do_op(8'd200, 8'd13, 1'b0, lat);
        chk("midrst_fresh_lat", lat, 9);
        chk("midrst_fresh_q", quotient, 15);
        chk("midrst_fresh_r", remainder, 5);

        // reset and start together: reset wins
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", busy, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("rst_start_no_done", ndone, 0);

        // random unsigned operands
        for (int k = 0; k < 40; k++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = N'($urandom_range(0, 255));
            rb = (k % 8 == 0) ? '0 : N'($urandom_range(0, 255));
            ref_div(ra, rb, 1'b0, eq, er);
            do_op(ra, rb, 1'b0, lat);
            chk($sformatf("rnd%0d_lat", k), lat, (rb == '0) ? 1 : N + 1);
            chk($sformatf("rnd%0d_q", k), quotient, eq);
            chk($sformatf("rnd%0d_r", k), remainder, er);
            chk($sformatf("rnd%0d_dz", k), div_by_zero, (rb == '0));
        end

`ifdef RESTORING_DIV_SIGNED_EN
        do_op(8'hEC, 8'd7, 1'b1, lat);
        chk("s_neg20_7_q", quotient, 8'hFE);
        chk("s_neg20_7_r", remainder, 8'hFA);
        chk("s_neg20_7_lat", lat, 9);
        do_op(8'd20, 8'hF9, 1'b1, lat);
        chk("s_20_neg7_q", quotient, 8'hFE);
        chk("s_20_neg7_r", remainder, 8'h06);
        do_op(8'h80, 8'hFF, 1'b1, lat);
        chk("s_min_neg1_q", quotient, 8'h80);
        chk("s_min_neg1_r", remainder, 8'h00);
        do_op(8'hF0, 8'h00, 1'b1, lat);
        chk("s_dz_q", quotient, 8'hFF);
        chk("s_dz_r", remainder, 8'hF0);
        chk("s_dz_flag", div_by_zero, 1);
        for (int k = 0; k < 30; k++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = N'($urandom_range(0, 255));
            rb = N'($urandom_range(0, 255));
            ref_div(ra, rb, 1'b1, eq, er);
            do_op(ra, rb, 1'b1, lat);
            chk($sformatf("srnd%0d_q", k), quotient, eq);
            chk($sformatf("srnd%0d_r", k), remainder, er);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
